// File: rtl/rf_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_ctrl
// Brief    : Writeback initiator for the register file. Buffers execute-stage
//            results in an in-order FIFO, drains one registered write per
//            cycle and forwards pending values to the operand-read side.
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_ctrl #(
    parameter int DEPTH = 2,
    parameter int AW    = 3,
    parameter int DW    = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_reg,
    input  logic [DW-1:0] in_data,
    input  logic          rf_stall,
    output logic          RegWrite,
    output logic [AW-1:0] WriteReg,
    output logic [DW-1:0] WriteData,
    input  logic [AW-1:0] fwd_reg,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
    output logic [CW-1:0] count,
    output logic          idle
);

    logic [AW-1:0] r_mem_reg  [DEPTH];
    logic [DW-1:0] r_mem_data [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Full/empty come from the occupancy counter, never from pointer equality.
    assign in_ready = (r_count != CW'(DEPTH));
    assign w_push   = in_valid & in_ready;
    assign w_pop    = (r_count != '0) & ~rf_stall;
    assign count    = r_count;
    assign idle     = (r_count == '0) & ~RegWrite;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_reg[i]  <= '0;
                r_mem_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_reg[r_wr_ptr]  <= in_reg;
                r_mem_data[r_wr_ptr] <= in_data;
                r_wr_ptr             <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                WriteReg  <= r_mem_reg[r_rd_ptr];
                WriteData <= r_mem_data[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + PW'(1);
            end
            RegWrite <= w_pop;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Scan from oldest to newest so the youngest match overrides; the output
    // stage is the oldest candidate of all.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (RegWrite && (WriteReg == fwd_reg)) begin
            fwd_hit  = 1'b1;
            fwd_data = WriteData;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < r_count) && (r_mem_reg[r_rd_ptr + PW'(k)] == fwd_reg)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_mem_data[r_rd_ptr + PW'(k)];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_ctrl
// Brief    : Scoreboard bench for rf_write_ctrl with directed and random phases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_ctrl;

    localparam int DEPTH = 2;
    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_reg;
    logic [DW-1:0] in_data;
    logic          rf_stall;
    logic          RegWrite;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic [AW-1:0] fwd_reg;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [CW-1:0] count;
    logic          idle;

    int n_vec = 0;
    int n_err = 0;
    logic [AW+DW-1:0] exp_q[$];

    rf_write_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .rf_stall(rf_stall),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard: accepted results are queued at the edge; every write pulse
    // must match the oldest outstanding result.
    always begin
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back({in_reg, in_data});
        end
        #1;
        if (!rst && RegWrite) begin
            if (exp_q.size() == 0) begin
                check_val("wr_unexpected", 32'(RegWrite), 32'd0);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                check_val("wr_reg",  32'(WriteReg),  32'(e[AW+DW-1:DW]));
                check_val("wr_data", 32'(WriteData), 32'(e[DW-1:0]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0; rf_stall = 1'b0; fwd_reg = '0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_count",    32'(count),     32'd0);
        check_val("rst_idle",     32'(idle),      32'd1);
        check_val("rst_in_ready", 32'(in_ready),  32'd1);
        check_val("rst_regwrite", 32'(RegWrite),  32'd0);
        check_val("rst_wreg",     32'(WriteReg),  32'd0);
        check_val("rst_wdata",    32'(WriteData), 32'd0);
        check_val("rst_fwd_hit",  32'(fwd_hit),   32'd0);
        check_val("rst_fwd_data", 32'(fwd_data),  32'd0);
        rst = 1'b0;

        // Reset while a result is buffered: it must never be written.
        @(negedge clk);
        in_valid = 1'b1; in_reg = 3'd3; in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        check_val("rstact_pre_count", 32'(count), 32'd1);
        rst = 1'b1;
        #1;
        check_val("rstact_count",    32'(count),    32'd0);
        check_val("rstact_idle",     32'(idle),     32'd1);
        check_val("rstact_in_ready", 32'(in_ready), 32'd1);
        check_val("rstact_regwrite", 32'(RegWrite), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_val("rstact_no_write", 32'(RegWrite), 32'd0);

        // Single result: two-edge latency, no bypass.
        in_valid = 1'b1; in_reg = 3'd5; in_data = 8'h2C;
        tick();
        in_valid = 1'b0;
        check_val("single_count",  32'(count),    32'd1);
        check_val("single_nobyp",  32'(RegWrite), 32'd0);
        tick();
        check_val("single_we",     32'(RegWrite),  32'd1);
        check_val("single_wreg",   32'(WriteReg),  32'd5);
        check_val("single_wdata",  32'(WriteData), 32'h2C);
        check_val("single_busy",   32'(idle),      32'd0);
        tick();
        check_val("single_we_off", 32'(RegWrite),  32'd0);
        check_val("single_idle",   32'(idle),      32'd1);
        check_val("single_hold",   32'(WriteData), 32'h2C);

        // Back-pressure: fill, refuse, then drain while the refused push waits.
        rf_stall = 1'b1;
        in_valid = 1'b1; in_reg = 3'd1; in_data = 8'h11;
        tick();
        in_reg = 3'd2; in_data = 8'h22;
        tick();
        check_val("bp_count_full", 32'(count),    32'd2);
        check_val("bp_not_ready",  32'(in_ready), 32'd0);
        in_reg = 3'd3; in_data = 8'h33;
        tick();
        check_val("bp_refused",    32'(count),    32'd2);
        check_val("bp_stall_we",   32'(RegWrite), 32'd0);
        rf_stall = 1'b0;
        tick();
        check_val("bp_pop1_count", 32'(count),    32'd1);
        check_val("bp_pop1_ready", 32'(in_ready), 32'd1);
        check_val("bp_pop1_reg",   32'(WriteReg), 32'd1);
        tick();
        in_valid = 1'b0;
        check_val("bp_pop2_reg",   32'(WriteReg), 32'd2);
        check_val("bp_pop2_count", 32'(count),    32'd1);
        tick();
        check_val("bp_pop3_reg",   32'(WriteReg), 32'd3);
        check_val("bp_pop3_count", 32'(count),    32'd0);
        tick();

        // Forwarding priority: newest FIFO entry, then the output stage.
        rf_stall = 1'b1;
        in_valid = 1'b1; in_reg = 3'd4; in_data = 8'h10;
        tick();
        in_data = 8'h20;
        tick();
        in_valid = 1'b0;
        fwd_reg = 3'd4;
        #1;
        check_val("fwd_hit_young",  32'(fwd_hit),  32'd1);
        check_val("fwd_data_young", 32'(fwd_data), 32'h20);
        fwd_reg = 3'd6;
        #1;
        check_val("fwd_miss_hit",   32'(fwd_hit),  32'd0);
        check_val("fwd_miss_data",  32'(fwd_data), 32'd0);
        fwd_reg = 3'd4;
        rf_stall = 1'b0;
        tick();
        check_val("fwd_fifo_over_out", 32'(fwd_data), 32'h20);
        tick();
        check_val("fwd_out_only",   32'(fwd_data), 32'h20);
        tick();
        check_val("fwd_gone",       32'(fwd_hit),  32'd0);

        // Output-stage forwarding with the FIFO empty.
        fwd_reg = 3'd7;
        in_valid = 1'b1; in_reg = 3'd7; in_data = 8'h7E;
        tick();
        in_valid = 1'b0;
        tick();
        check_val("ofwd_empty",  32'(count),    32'd0);
        check_val("ofwd_we",     32'(RegWrite), 32'd1);
        check_val("ofwd_hit",    32'(fwd_hit),  32'd1);
        check_val("ofwd_data",   32'(fwd_data), 32'h7E);
        tick();

        // Full-rate streaming through R0..R7 with pointer wrap.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_reg = AW'(i); in_data = DW'(8'h80 + i);
            tick();
            check_val("stream_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check_val("stream_idle",  32'(idle),         32'd1);
        check_val("stream_drain", 32'(exp_q.size()), 32'd0);

        // Random traffic with intermittent stalls.
        for (int c = 0; c < 200; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_reg   = AW'($urandom);
            in_data  = DW'($urandom);
            rf_stall = ($urandom_range(0, 3) == 0);
            tick();
        end
        in_valid = 1'b0; rf_stall = 1'b0;
        repeat (DEPTH + 3) tick();
        check_val("rand_idle",  32'(idle),         32'd1);
        check_val("rand_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
